sha256_round_stage: RTL and testbench

- Downstream neighbour of the message-schedule expansion stage in the pipelined SHA-256 miner.
- Takes the DELAY freshly expanded schedule words from the expander's output window, plus the 8-word working state a..h.
- Applies DELAY SHA-256 compression rounds, one per clock, using an internal K-constant ROM offset by ROUND_BASE.
- Presents the updated working state to the next round stage with a one-cycle valid pulse.

---
 rtl/sha256_round_stage.sv | 152 +++++++++++++++
 tb/tb_sha256_round_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_stage.sv
// sha256_round_stage
// One stage of the pipelined SHA-256 compressor. On a start request it
// captures the working state a..h and the last DELAY words of the schedule
// window, then runs DELAY compression rounds (one per clock) using K
// constants starting at global round ROUND_BASE. The resulting state is
// presented on Hout together with a single-cycle valid pulse.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low reset
//   en     - start request, only honoured while idle
//   Hin    - working state in, word i at [i*WORD_S +: WORD_S], word 0 = a
//   Win    - schedule window, round j uses word W_BLKCNT-DELAY+j
//   busy   - high while rounds are executing
//   valid  - one-cycle pulse when Hout has been updated
//   Hout   - resulting working state, same layout as Hin, held between results
module sha256_round_stage #(
   parameter int WORD_S     = 32,
   parameter int W_BLKCNT   = 16,
   parameter int DELAY      = 4,
   parameter int ROUND_BASE = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [8*WORD_S-1:0]          Hin,
   input  logic [W_BLKCNT*WORD_S-1:0]   Win,
   output logic                         busy,
   output logic                         valid,
   output logic [8*WORD_S-1:0]          Hout
);

   localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

   localparam logic [WORD_S-1:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [WORD_S-1:0] wv [8];
   logic [WORD_S-1:0] w_buf [DELAY];
   logic              done;
   logic              capture;
   logic              last_round;
   logic [5:0]        k_idx;
   logic [WORD_S-1:0] t1;
   logic [WORD_S-1:0] t2;

   function automatic logic [WORD_S-1:0] rotr(input logic [WORD_S-1:0] x, input int s);
      return (x >> s) | (x << (WORD_S - s));
   endfunction

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next state: a start is only taken while idle, and the final round
   // returns to IDLE so a new start can be accepted in the valid cycle.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      last_round = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               capture    = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt == CNT_LAST) begin
               last_round = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One compression round on the current a..h registers
   always_comb begin
      k_idx = 6'(ROUND_BASE) + 6'(cnt);
      t1 = wv[7]
         + (rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25))
         + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6]))
         + K_ROM[k_idx]
         + w_buf[cnt];
      t2 = (rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22))
         + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
   end

   // Datapath. The result is published one cycle after the last round, so
   // Hout reads the settled a..h registers even if a new capture overwrites
   // them on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         done  <= 1'b0;
         valid <= 1'b0;
         Hout  <= '0;
         for (int i = 0; i < 8; i++) wv[i] <= '0;
         for (int j = 0; j < DELAY; j++) w_buf[j] <= '0;
      end else begin
         done  <= last_round;
         valid <= done;
         if (done) begin
            for (int i = 0; i < 8; i++) Hout[i*WORD_S +: WORD_S] <= wv[i];
         end
         if (capture) begin
            cnt <= '0;
            for (int i = 0; i < 8; i++) wv[i] <= Hin[i*WORD_S +: WORD_S];
            for (int j = 0; j < DELAY; j++)
               w_buf[j] <= Win[(W_BLKCNT - DELAY + j)*WORD_S +: WORD_S];
         end else if (state == RUN) begin
            wv[7] <= wv[6];
            wv[6] <= wv[5];
            wv[5] <= wv[4];
            wv[4] <= wv[3] + t1;
            wv[3] <= wv[2];
            wv[2] <= wv[1];
            wv[1] <= wv[0];
            wv[0] <= t1 + t2;
            cnt   <= last_round ? '0 : cnt + CNT_W'(1);
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_sha256_round_stage.sv
// tb_sha256_round_stage
// Randomised scoreboard bench for sha256_round_stage. A reference model
// predicts which start requests are accepted and the resulting state; a
// monitor on the falling edge pops predictions when valid is seen. A second
// instance with DELAY=1, ROUND_BASE=0 is checked against the first round of
// the well-known "abc" digest.
module tb_sha256_round_stage;

   localparam int D  = 4;
   localparam int RB = 16;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic         clk;
   logic         reset;
   logic         en;
   logic [255:0] Hin;
   logic [511:0] Win;
   logic         busy;
   logic         valid;
   logic [255:0] Hout;

   logic         en1;
   logic [255:0] Hin1;
   logic [511:0] Win1;
   logic         busy1;
   logic         valid1;
   logic [255:0] Hout1;

   typedef struct {
      logic [255:0] h;
      int           due;
   } exp_t;

   exp_t         q[$];
   int           cyc;
   int           cooldown;
   logic [255:0] last_h;
   int           n_checks;
   int           n_fail;

   sha256_round_stage dut (
      .clk(clk), .reset(reset), .en(en), .Hin(Hin), .Win(Win),
      .busy(busy), .valid(valid), .Hout(Hout)
   );

   sha256_round_stage #(.DELAY(1), .ROUND_BASE(0)) dut1 (
      .clk(clk), .reset(reset), .en(en1), .Hin(Hin1), .Win(Win1),
      .busy(busy1), .valid(valid1), .Hout(Hout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ror(input logic [31:0] x, input int s);
      logic [63:0] d;
      d = {x, x} >> s;
      return d[31:0];
   endfunction

   // Textbook SHA-256 rounds over an array of eight words
   function automatic logic [255:0] model(input logic [255:0] h_in, input logic [511:0] w_in,
                                          input int base, input int n);
      logic [31:0]  v [8];
      logic [31:0]  x1;
      logic [31:0]  x2;
      logic [31:0]  w;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) v[i] = h_in[i*32 +: 32];
      for (int j = 0; j < n; j++) begin
         w  = w_in[(16 - n + j)*32 +: 32];
         x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[base + j] + w;
         x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + x1;
         v[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = v[i];
      return r;
   endfunction

   function automatic logic [255:0] rand_h();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] rand_w();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs; called and returns 1 time unit after a rising edge
   task automatic applyStimulus(input logic e, input logic [255:0] h, input logic [511:0] w);
      en  = e;
      Hin = h;
      Win = w;
      @(posedge clk);
      #1;
   endtask

   // Reference: acceptance while idle, DELAY ignored edges afterwards,
   // result visible after the (DELAY+1)th edge following the start.
   initial begin
      cyc      = 0;
      cooldown = 0;
      last_h   = '0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            q.delete();
            cooldown = 0;
            last_h   = '0;
         end else begin
            cyc++;
            if (cooldown > 0) cooldown--;
            else if (en) begin
               q.push_back('{model(Hin, Win, RB, D), cyc + D + 1});
               cooldown = D;
            end
         end
      end
   end

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         checkOutput("busy", busy, cooldown > 0);
         if (valid === 1'b1) begin
            checkOutput("valid_has_job", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               checkOutput("valid_time", cyc, e.due);
               checkOutput("hout", Hout, e.h);
               last_h = e.h;
            end
         end else begin
            checkOutput("valid_level", valid, 0);
            if (q.size() != 0 && q[0].due <= cyc) begin
               checkOutput("valid_missing", cyc, q[0].due);
               void'(q.pop_front());
            end
            checkOutput("hout_hold", Hout, last_h);
         end
      end
   end

   initial begin
      logic [255:0] hab;
      logic [255:0] expab;
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b0;
      en    = 1'b0;
      Hin   = '0;
      Win   = '0;
      en1   = 1'b0;
      Hin1  = '0;
      Win1  = '0;

      // Reset then idle
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (10) applyStimulus(1'b0, rand_h(), rand_w());

      // Single round against the first round of SHA-256("abc")
      hab   = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
               32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
      expab = {32'h1F83D9AB, 32'h9B05688C, 32'h510E527F, 32'hFA2A4622,
               32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667, 32'h5D6AEBCD};
      Hin1 = hab;
      Win1 = rand_w();
      Win1[15*32 +: 32] = 32'h61626380;
      en1  = 1'b1;
      @(posedge clk); #1;
      en1  = 1'b0;
      Hin1 = rand_h();
      checkOutput("d1_busy_run", busy1, 1);
      checkOutput("d1_valid_early", valid1, 0);
      @(posedge clk); #1;
      checkOutput("d1_busy_done", busy1, 0);
      checkOutput("d1_valid_early2", valid1, 0);
      @(posedge clk); #1;
      checkOutput("d1_valid", valid1, 1);
      checkOutput("d1_hout", Hout1, expab);
      @(posedge clk); #1;
      checkOutput("d1_valid_pulse", valid1, 0);
      checkOutput("d1_hout_hold", Hout1, expab);

      // Isolated random jobs
      repeat (3) begin
         applyStimulus(1'b1, rand_h(), rand_w());
         repeat (6) applyStimulus(1'b0, rand_h(), rand_w());
      end

      // en held high with Hin changing every cycle
      repeat (20) applyStimulus(1'b1, rand_h(), rand_w());
      repeat (6) applyStimulus(1'b0, rand_h(), rand_w());

      // All-ones wraparound
      applyStimulus(1'b1, {256{1'b1}}, {512{1'b1}});
      repeat (6) applyStimulus(1'b0, rand_h(), rand_w());

      // Abort in the second RUN cycle
      applyStimulus(1'b1, rand_h(), rand_w());
      en = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_valid", valid, 0);
      checkOutput("abort_hout", Hout, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      applyStimulus(1'b1, rand_h(), rand_w());
      repeat (6) applyStimulus(1'b0, rand_h(), rand_w());

      // Mixed random traffic
      repeat (40) applyStimulus($urandom_range(0, 2) == 0, rand_h(), rand_w());

      en = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("drain", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
